mem_miss_sequencer: RTL
=======================

MEM_MISS_SEQUENCER -- requirements
Module: mem_miss_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning memory address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning width of each miss counter.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port i_icache_hit, input, 1, fetch-stage icache hit; 0 means an instruction miss is pending.
REQ-006 SHALL have port i_mem_access, input, 1, memory-stage instruction accesses the dcache.
REQ-007 SHALL have port i_dcache_hit, input, 1, dcache hit for the memory-stage access.
REQ-008 SHALL have port i_dcache_dirty, input, 1, victim line of the dcache miss is dirty.
REQ-009 SHALL have port i_addr_i, input, ADDR_WIDTH, icache miss address.
REQ-010 SHALL have port i_addr_d, input, ADDR_WIDTH, dcache miss address.
REQ-011 SHALL have port i_addr_wb, input, ADDR_WIDTH, dirty-victim write-back address.
REQ-012 SHALL have port i_axi_read_done, input, 1, one-cycle pulse: read block returned.
REQ-013 SHALL have port i_axi_write_done, input, 1, one-cycle pulse: write-back block accepted.
REQ-014 SHALL have port o_axi_read_req, output, 1, level read request.
REQ-015 SHALL have port o_axi_write_req, output, 1, level write-back request.
REQ-016 SHALL have port o_axi_addr, output, ADDR_WIDTH, address of the active AXI transaction.
REQ-017 SHALL have port o_instr_we, output, 1, icache block write enable.
REQ-018 SHALL have port o_dcache_we, output, 1, dcache block write enable.
REQ-019 SHALL have port o_stall, output, 1, freezes all pipeline stages.
REQ-020 SHALL have port o_icache_miss_cnt, output, CNT_WIDTH, serviced icache misses.
REQ-021 SHALL have port o_dcache_miss_cnt, output, CNT_WIDTH, serviced dcache misses.

Function
REQ-022 SHALL have FSM states IDLE, D_WB, D_RD, D_FILL, I_RD, I_FILL.
REQ-023 SHALL define dmiss = i_mem_access & ~i_dcache_hit and imiss = ~i_icache_hit.
REQ-024 SHALL transition IDLE->D_WB if dmiss & i_dcache_dirty, latching i_addr_wb into the address register.
REQ-025 SHALL transition IDLE->D_RD if dmiss & ~i_dcache_dirty, latching i_addr_d.
REQ-026 SHALL transition IDLE->I_RD if imiss & ~dmiss, latching i_addr_i; dmiss wins when both are pending.
REQ-027 SHALL, in D_WB, hold o_axi_write_req=1 and, on i_axi_write_done, go to D_RD, latching i_addr_d.
REQ-028 SHALL, in D_RD/I_RD, hold o_axi_read_req=1 and, on i_axi_read_done, go to D_FILL/I_FILL.
REQ-029 SHALL, in D_FILL, assert o_dcache_we for exactly one cycle, increment o_dcache_miss_cnt, return to IDLE.
REQ-030 SHALL, in I_FILL, assert o_instr_we for exactly one cycle, increment o_icache_miss_cnt, return to IDLE.
REQ-031 SHALL drive o_axi_addr from the latched register only; input address changes after latching have no effect.
REQ-032 SHALL drive o_stall = (state != IDLE) | dmiss | imiss, combinationally, so the stall starts in the cycle the miss appears.
REQ-033 SHALL ignore done pulses arriving in states that do not expect them (read done in D_WB, write done in D_RD, any done in IDLE/FILL).
REQ-034 SHALL saturate each counter at all-ones (no wrap).
REQ-035 SHALL serve a pending imiss after a dcache service completes via a normal IDLE->I_RD pass (one IDLE cycle minimum).
REQ-036 SHALL never assert o_axi_read_req and o_axi_write_req together, nor o_instr_we and o_dcache_we together.

Reset
REQ-037 SHALL, while i_rstn=0 at a clock edge, enter IDLE and zero the address register and both counters.
REQ-038 SHALL, during reset, drive o_axi_read_req, o_axi_write_req, o_instr_we, o_dcache_we = 0 and o_axi_addr = 0; o_stall follows REQ-032.
REQ-039 SHALL, when reset is asserted mid-transaction, abandon the transaction with no fill pulse and no counter increment.

Verification
REQ-040 SHALL cover: imiss, i_addr_i=0x1000, read done 5 cycles after req -> o_axi_addr=0x1000, o_instr_we one cycle after done, icache count=1.
REQ-041 SHALL cover: dirty dmiss, wb=0x2040, d=0x3000 -> write_req with addr 0x2040; after write done, read_req with addr 0x3000; o_dcache_we pulses once.
REQ-042 SHALL cover: imiss and clean dmiss in the same cycle -> dcache served first, then one IDLE cycle, then I_RD; both counters=1.
REQ-043 SHALL cover: spurious read done in IDLE and write done in D_RD -> no state change, no enable pulses.
REQ-044 SHALL cover: i_rstn=0 in D_RD after 2 cycles -> next edge IDLE, req=0, no fill pulse, counters=0.
REQ-045 SHALL cover: preload dcache count to max via 2^CNT_WIDTH-1 misses (CNT_WIDTH=4 build) -> stays 15 after 16th miss.

Source files
------------

// File: rtl/mem_miss_sequencer.sv
// Miss sequencer: services one icache or dcache miss at a time over a single AXI port,
// with an optional dirty-victim write-back ahead of the dcache refill.
module mem_miss_sequencer #(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_icache_hit,
    input  logic                  i_mem_access,
    input  logic                  i_dcache_hit,
    input  logic                  i_dcache_dirty,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_d,
    input  logic [ADDR_WIDTH-1:0] i_addr_wb,
    input  logic                  i_axi_read_done,
    input  logic                  i_axi_write_done,
    output logic                  o_axi_read_req,
    output logic                  o_axi_write_req,
    output logic [ADDR_WIDTH-1:0] o_axi_addr,
    output logic                  o_instr_we,
    output logic                  o_dcache_we,
    output logic                  o_stall,
    output logic [CNT_WIDTH-1:0]  o_icache_miss_cnt,
    output logic [CNT_WIDTH-1:0]  o_dcache_miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_D_WB   = 3'd1,
        S_D_RD   = 3'd2,
        S_D_FILL = 3'd3,
        S_I_RD   = 3'd4,
        S_I_FILL = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_addr_load;
    logic [CNT_WIDTH-1:0]  r_icnt;
    logic [CNT_WIDTH-1:0]  r_dcnt;
    logic                  w_dmiss;
    logic                  w_imiss;

    // Counters stick at all-ones so a long run never reports a small count.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign w_dmiss = i_mem_access & ~i_dcache_hit;
    assign w_imiss = ~i_icache_hit;

    // State and latched transaction address.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_addr  <= {ADDR_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_next;
            if (w_addr_load) begin
                r_addr <= w_addr_next;
            end
        end
    end

    // Serviced-miss counters, bumped as the fill state is left.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_icnt <= {CNT_WIDTH{1'b0}};
            r_dcnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (r_state == S_I_FILL) begin
                r_icnt <= sat_inc(r_icnt);
            end
            if (r_state == S_D_FILL) begin
                r_dcnt <= sat_inc(r_dcnt);
            end
        end
    end

    // Next-state and address-latch selection; dcache misses take priority.
    always_comb begin
        w_state_next = r_state;
        w_addr_load  = 1'b0;
        w_addr_next  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (w_dmiss && i_dcache_dirty) begin
                    w_state_next = S_D_WB;
                    w_addr_load  = 1'b1;
                    w_addr_next  = i_addr_wb;
                end else if (w_dmiss) begin
                    w_state_next = S_D_RD;
                    w_addr_load  = 1'b1;
                    w_addr_next  = i_addr_d;
                end else if (w_imiss) begin
                    w_state_next = S_I_RD;
                    w_addr_load  = 1'b1;
                    w_addr_next  = i_addr_i;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_D_WB: begin
                if (i_axi_write_done) begin
                    w_state_next = S_D_RD;
                    w_addr_load  = 1'b1;
                    w_addr_next  = i_addr_d;
                end else begin
                    w_state_next = S_D_WB;
                end
            end
            S_D_RD: begin
                if (i_axi_read_done) begin
                    w_state_next = S_D_FILL;
                end else begin
                    w_state_next = S_D_RD;
                end
            end
            S_I_RD: begin
                if (i_axi_read_done) begin
                    w_state_next = S_I_FILL;
                end else begin
                    w_state_next = S_I_RD;
                end
            end
            S_D_FILL: w_state_next = S_IDLE;
            S_I_FILL: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Moore outputs from the registered state, forced low while reset is held.
    always_comb begin
        o_axi_read_req  = 1'b0;
        o_axi_write_req = 1'b0;
        o_instr_we      = 1'b0;
        o_dcache_we     = 1'b0;
        case (r_state)
            S_D_WB:   o_axi_write_req = i_rstn;
            S_D_RD:   o_axi_read_req  = i_rstn;
            S_I_RD:   o_axi_read_req  = i_rstn;
            S_D_FILL: o_dcache_we     = i_rstn;
            S_I_FILL: o_instr_we      = i_rstn;
            default: begin
                o_axi_read_req  = 1'b0;
                o_axi_write_req = 1'b0;
            end
        endcase
        if (i_rstn) begin
            o_axi_addr = r_addr;
        end else begin
            o_axi_addr = {ADDR_WIDTH{1'b0}};
        end
        o_stall = (r_state != S_IDLE) | w_dmiss | w_imiss;
    end

    assign o_icache_miss_cnt = r_icnt;
    assign o_dcache_miss_cnt = r_dcnt;

endmodule
